// File: rtl/instr_decode_queue_pkg.sv
// rtl/instr_decode_queue_pkg.sv - cpu_pkg: decoded instruction IDs and RV32 opcodes
// Exports ID_* constants (ADD=0 .. AUIPC=44, UNKNOWN=45) and OP_* major opcodes.
package cpu_pkg;

    localparam logic [5:0] ID_ADD     = 6'd0;
    localparam logic [5:0] ID_SUB     = 6'd1;
    localparam logic [5:0] ID_SLL     = 6'd2;
    localparam logic [5:0] ID_SLT     = 6'd3;
    localparam logic [5:0] ID_SLTU    = 6'd4;
    localparam logic [5:0] ID_XOR     = 6'd5;
    localparam logic [5:0] ID_SRL     = 6'd6;
    localparam logic [5:0] ID_SRA     = 6'd7;
    localparam logic [5:0] ID_OR      = 6'd8;
    localparam logic [5:0] ID_AND     = 6'd9;
    localparam logic [5:0] ID_MUL     = 6'd10;
    localparam logic [5:0] ID_MULH    = 6'd11;
    localparam logic [5:0] ID_MULHSU  = 6'd12;
    localparam logic [5:0] ID_MULHU   = 6'd13;
    localparam logic [5:0] ID_DIV     = 6'd14;
    localparam logic [5:0] ID_DIVU    = 6'd15;
    localparam logic [5:0] ID_REM     = 6'd16;
    localparam logic [5:0] ID_REMU    = 6'd17;
    localparam logic [5:0] ID_ADDI    = 6'd18;
    localparam logic [5:0] ID_SLTI    = 6'd19;
    localparam logic [5:0] ID_SLTIU   = 6'd20;
    localparam logic [5:0] ID_XORI    = 6'd21;
    localparam logic [5:0] ID_ORI     = 6'd22;
    localparam logic [5:0] ID_ANDI    = 6'd23;
    localparam logic [5:0] ID_SLLI    = 6'd24;
    localparam logic [5:0] ID_SRLI    = 6'd25;
    localparam logic [5:0] ID_SRAI    = 6'd26;
    localparam logic [5:0] ID_LB      = 6'd27;
    localparam logic [5:0] ID_LH      = 6'd28;
    localparam logic [5:0] ID_LW      = 6'd29;
    localparam logic [5:0] ID_LBU     = 6'd30;
    localparam logic [5:0] ID_LHU     = 6'd31;
    localparam logic [5:0] ID_SB      = 6'd32;
    localparam logic [5:0] ID_SH      = 6'd33;
    localparam logic [5:0] ID_SW      = 6'd34;
    localparam logic [5:0] ID_BEQ     = 6'd35;
    localparam logic [5:0] ID_BNE     = 6'd36;
    localparam logic [5:0] ID_BLT     = 6'd37;
    localparam logic [5:0] ID_BGE     = 6'd38;
    localparam logic [5:0] ID_BLTU    = 6'd39;
    localparam logic [5:0] ID_BGEU    = 6'd40;
    localparam logic [5:0] ID_JAL     = 6'd41;
    localparam logic [5:0] ID_JALR    = 6'd42;
    localparam logic [5:0] ID_LUI     = 6'd43;
    localparam logic [5:0] ID_AUIPC   = 6'd44;
    localparam logic [5:0] ID_UNKNOWN = 6'd45;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/instr_decode_queue_if.sv
// rtl/instr_decode_queue_if.sv - fetch-side and execute-side handshakes of the decode queue
// master: fetch/execute (drives in_valid/in_instr/in_pc/out_ready); slave: the queue.
interface instr_decode_queue_if #(
    parameter int ID_W = 6
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [31:0]     in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [31:0]     out_pc;
    logic [ID_W-1:0] out_id;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_id, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_id, out_illegal
    );
endinterface

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational RV32I(+M) decoder to a compact instruction ID
// Ports: instr (32-bit word in), id (ID_W-bit decoded ID out). ENABLE_M=0 maps RV32M to unknown.
module instr_decoder
    import cpu_pkg::*;
#(
    parameter int ENABLE_M = 1,
    parameter int ID_W     = 6
) (
    input  logic [31:0]     instr,
    output logic [ID_W-1:0] id
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [5:0] id_raw;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    always_comb begin
        id_raw = ID_UNKNOWN;
        case (opcode)
            OP_R: begin
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'd0: id_raw = ID_ADD;
                            3'd1: id_raw = ID_SLL;
                            3'd2: id_raw = ID_SLT;
                            3'd3: id_raw = ID_SLTU;
                            3'd4: id_raw = ID_XOR;
                            3'd5: id_raw = ID_SRL;
                            3'd6: id_raw = ID_OR;
                            default: id_raw = ID_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'd0) id_raw = ID_SUB;
                        else if (funct3 == 3'd5) id_raw = ID_SRA;
                    end
                    // MUL..REMU are numbered in funct3 order
                    7'b0000001: if (ENABLE_M != 0) id_raw = ID_MUL + {3'b000, funct3};
                    default: ;
                endcase
            end
            OP_IMM: begin
                case (funct3)
                    3'd0: id_raw = ID_ADDI;
                    3'd1: if (funct7 == 7'b0000000) id_raw = ID_SLLI;
                    3'd2: id_raw = ID_SLTI;
                    3'd3: id_raw = ID_SLTIU;
                    3'd4: id_raw = ID_XORI;
                    3'd5: begin
                        if (funct7 == 7'b0000000) id_raw = ID_SRLI;
                        else if (funct7 == 7'b0100000) id_raw = ID_SRAI;
                    end
                    3'd6: id_raw = ID_ORI;
                    default: id_raw = ID_ANDI;
                endcase
            end
            OP_LOAD: begin
                case (funct3)
                    3'd0: id_raw = ID_LB;
                    3'd1: id_raw = ID_LH;
                    3'd2: id_raw = ID_LW;
                    3'd4: id_raw = ID_LBU;
                    3'd5: id_raw = ID_LHU;
                    default: ;
                endcase
            end
            OP_STORE: begin
                case (funct3)
                    3'd0: id_raw = ID_SB;
                    3'd1: id_raw = ID_SH;
                    3'd2: id_raw = ID_SW;
                    default: ;
                endcase
            end
            OP_BRANCH: begin
                case (funct3)
                    3'd0: id_raw = ID_BEQ;
                    3'd1: id_raw = ID_BNE;
                    3'd4: id_raw = ID_BLT;
                    3'd5: id_raw = ID_BGE;
                    3'd6: id_raw = ID_BLTU;
                    3'd7: id_raw = ID_BGEU;
                    default: ;
                endcase
            end
            OP_JAL:   id_raw = ID_JAL;
            OP_JALR:  if (funct3 == 3'd0) id_raw = ID_JALR;
            OP_LUI:   id_raw = ID_LUI;
            OP_AUIPC: id_raw = ID_AUIPC;
            default: ;
        endcase
    end

    assign id = ID_W'(id_raw);
endmodule

// File: rtl/instr_decode_queue.sv
// rtl/instr_decode_queue.sv - decode-at-write instruction FIFO between fetch and execute
// Ports: clk, rst (async, active-high), q (slave handshakes), flush, count (occupied entries).
module instr_decode_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ENABLE_M = 1,
    parameter int ID_W     = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    instr_decode_queue_if.slave          q,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] rp_q, rp_d, wp_q, wp_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0]     instr_mem_q [DEPTH];
    logic [31:0]     pc_mem_q    [DEPTH];
    logic [ID_W-1:0] id_mem_q    [DEPTH];
    logic            ill_mem_q   [DEPTH];

    logic [ID_W-1:0] dec_id;
    logic            push, pop;

    instr_decoder #(.ENABLE_M(ENABLE_M), .ID_W(ID_W)) u_dec (
        .instr (q.in_instr),
        .id    (dec_id)
    );

    // Handshake status comes only from registered count.
    assign q.in_ready  = (count_q != CNT_W'(DEPTH));
    assign q.out_valid = (count_q != '0);
    assign count       = count_q;

    assign push = q.in_valid  && q.in_ready  && !flush;
    assign pop  = q.out_valid && q.out_ready && !flush;

    always_comb begin
        rp_d    = rp_q;
        wp_d    = wp_q;
        count_d = count_q;
        if (flush) begin
            rp_d    = '0;
            wp_d    = '0;
            count_d = '0;
        end else begin
            if (push) wp_d = wp_q + 1'b1;
            if (pop)  rp_d = rp_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp_q    <= '0;
            wp_q    <= '0;
            count_q <= '0;
        end else begin
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            count_q <= count_d;
        end
    end

    // Entry contents need no reset; they are only observed while out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wp_q] <= q.in_instr;
            pc_mem_q[wp_q]    <= q.in_pc;
            id_mem_q[wp_q]    <= dec_id;
            ill_mem_q[wp_q]   <= (dec_id == ID_W'(ID_UNKNOWN));
        end
    end

    assign q.out_instr   = q.out_valid ? instr_mem_q[rp_q] : 32'd0;
    assign q.out_pc      = q.out_valid ? pc_mem_q[rp_q]    : 32'd0;
    assign q.out_id      = q.out_valid ? id_mem_q[rp_q]    : ID_W'(ID_UNKNOWN);
    assign q.out_illegal = q.out_valid && ill_mem_q[rp_q];
endmodule

// File: tb/tb_instr_decode_queue.sv
// tb/tb_instr_decode_queue.sv - self-checking bench for instr_decode_queue (ENABLE_M=1 and 0)
module tb_instr_decode_queue;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [2:0] count_a, count_b;

    instr_decode_queue_if #(.ID_W(6)) qa ();
    instr_decode_queue_if #(.ID_W(6)) qb ();

    assign qb.in_valid  = qa.in_valid;
    assign qb.in_instr  = qa.in_instr;
    assign qb.in_pc     = qa.in_pc;
    assign qb.out_ready = qa.out_ready;

    instr_decode_queue #(.DEPTH(DEPTH), .ENABLE_M(1), .ID_W(6)) dut_a (
        .clk(clk), .rst(rst), .q(qa.slave), .flush(flush), .count(count_a));
    instr_decode_queue #(.DEPTH(DEPTH), .ENABLE_M(0), .ID_W(6)) dut_b (
        .clk(clk), .rst(rst), .q(qb.slave), .flush(flush), .count(count_b));

    always #5 clk = ~clk;

    // ISA match patterns indexed by instruction ID.
    localparam logic [31:0] MATCH [0:44] = '{
        32'h00000033, 32'h40000033, 32'h00001033, 32'h00002033, 32'h00003033,
        32'h00004033, 32'h00005033, 32'h40005033, 32'h00006033, 32'h00007033,
        32'h02000033, 32'h02001033, 32'h02002033, 32'h02003033,
        32'h02004033, 32'h02005033, 32'h02006033, 32'h02007033,
        32'h00000013, 32'h00002013, 32'h00003013, 32'h00004013, 32'h00006013, 32'h00007013,
        32'h00001013, 32'h00005013, 32'h40005013,
        32'h00000003, 32'h00001003, 32'h00002003, 32'h00004003, 32'h00005003,
        32'h00000023, 32'h00001023, 32'h00002023,
        32'h00000063, 32'h00001063, 32'h00004063, 32'h00005063, 32'h00006063, 32'h00007063,
        32'h0000006F, 32'h00000067, 32'h00000037, 32'h00000017
    };

    function automatic logic [31:0] ref_mask(input int id);
        if (id <= 17 || (id >= 24 && id <= 26)) return 32'hFE00707F;
        if (id == 41 || id >= 43) return 32'h0000007F;
        return 32'h0000707F;
    endfunction

    function automatic int ref_id(input logic [31:0] w, input bit en_m);
        for (int i = 0; i < 45; i++)
            if ((w & ref_mask(i)) == MATCH[i] && (en_m || i < 10 || i > 17)) return i;
        return 45;
    endfunction

    function automatic logic [31:0] rand_word();
        int id;
        if ($urandom_range(0, 3) == 0) return $urandom;
        id = $urandom_range(0, 44);
        return MATCH[id] | ($urandom & ~ref_mask(id));
    endfunction

    logic [63:0] mq[$];
    int pass_cnt  = 0;
    int total_cnt = 0;

    function automatic logic [31:0] exp_instr();
        return (mq.size() != 0) ? mq[0][31:0] : 32'd0;
    endfunction
    function automatic logic [31:0] exp_pc();
        return (mq.size() != 0) ? mq[0][63:32] : 32'd0;
    endfunction
    function automatic logic [5:0] exp_id(input bit en_m);
        return (mq.size() != 0) ? 6'(ref_id(mq[0][31:0], en_m)) : 6'd45;
    endfunction

    task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                         input bit ordy, input bit fl);
        bit do_push, do_pop;
        qa.in_valid = v; qa.in_instr = ins; qa.in_pc = pc; qa.out_ready = ordy; flush = fl;
        @(posedge clk);
        do_pop  = (mq.size() != 0) && ordy && !fl;
        do_push = v && (mq.size() != DEPTH) && !fl;
        if (fl) mq.delete();
        else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({pc, ins});
        end
        #1;
    endtask

    task automatic test_reset();
        qa.in_valid = 0; qa.in_instr = 0; qa.in_pc = 0; qa.out_ready = 0; flush = 0;
        rst = 1;
        #3;
        total_cnt++; if (count_a !== 3'd0) $display("FAIL reset_count got %0d want 0", count_a); else pass_cnt++;
        total_cnt++; if ({qa.out_valid, qa.in_ready} !== 2'b01)
            $display("FAIL reset_handshake got v=%0b r=%0b want v=0 r=1", qa.out_valid, qa.in_ready); else pass_cnt++;
        total_cnt++; if ({qa.out_instr, qa.out_pc, qa.out_id, qa.out_illegal} !== {32'd0, 32'd0, 6'd45, 1'b0})
            $display("FAIL reset_out got instr=%h pc=%h id=%0d ill=%0b want 0 0 45 0",
                     qa.out_instr, qa.out_pc, qa.out_id, qa.out_illegal); else pass_cnt++;
        rst = 0;
    endtask

    task automatic test_addi();
        drive(1, 32'h00500093, 32'h100, 0, 0);
        total_cnt++; if ({qa.out_valid, qa.out_id, qa.out_pc, count_a} !== {1'b1, 6'd18, 32'h100, 3'd1})
            $display("FAIL addi_push got v=%0b id=%0d pc=%h cnt=%0d want 1 18 100 1",
                     qa.out_valid, qa.out_id, qa.out_pc, count_a); else pass_cnt++;
        drive(0, 0, 0, 1, 0);
        total_cnt++; if ({count_a, qa.out_id, qa.out_valid} !== {3'd0, 6'd45, 1'b0})
            $display("FAIL addi_pop got cnt=%0d id=%0d v=%0b want 0 45 0", count_a, qa.out_id, qa.out_valid); else pass_cnt++;
    endtask

    task automatic test_order_and_m();
        logic [31:0] w [3] = '{32'h402081B3, 32'h022081B3, 32'h0000006F};
        logic [5:0]  ida [3] = '{6'd1, 6'd10, 6'd41};
        logic [5:0]  idb [3] = '{6'd1, 6'd45, 6'd41};
        for (int i = 0; i < 3; i++) drive(1, w[i], 32'h200 + 32'(4 * i), 0, 0);
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if ({qa.out_id, qa.out_illegal, qa.out_pc} !== {ida[i], 1'b0, 32'h200 + 32'(4 * i)})
                $display("FAIL order_m1[%0d] got id=%0d ill=%0b pc=%h want id=%0d", i, qa.out_id, qa.out_illegal, qa.out_pc, ida[i]);
            else pass_cnt++;
            total_cnt++; if ({qb.out_id, qb.out_illegal} !== {idb[i], idb[i] == 6'd45})
                $display("FAIL order_m0[%0d] got id=%0d ill=%0b want id=%0d", i, qb.out_id, qb.out_illegal, idb[i]);
            else pass_cnt++;
            drive(0, 0, 0, 1, 0);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            drive(1, rand_word(), 32'h300 + 32'(4 * i), 0, 0);
            if (i >= 3) begin
                total_cnt++; if ({qa.in_ready, count_a} !== {1'b0, 3'd4})
                    $display("FAIL full_%0d got rdy=%0b cnt=%0d want 0 4", i, qa.in_ready, count_a); else pass_cnt++;
            end
        end
        drive(1, 32'h00000013, 32'h3F0, 1, 0);
        total_cnt++; if ({count_a, qa.in_ready, qa.out_pc} !== {3'd3, 1'b1, 32'h304})
            $display("FAIL full_pop_push got cnt=%0d rdy=%0b pc=%h want 3 1 304", count_a, qa.in_ready, qa.out_pc); else pass_cnt++;
        drive(0, 0, 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        drive(1, rand_word(), 32'h400, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            drive(1, rand_word(), 32'h400 + 32'(4 * i), 1, 0);
            total_cnt++; if ({count_a, qa.out_pc, qa.out_instr} !== {3'd1, 32'h400 + 32'(4 * i), exp_instr()})
                $display("FAIL b2b_%0d got cnt=%0d pc=%h instr=%h want 1 %h %h", i, count_a, qa.out_pc, qa.out_instr,
                         32'h400 + 32'(4 * i), exp_instr()); else pass_cnt++;
        end
        drive(0, 0, 0, 1, 0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) drive(1, rand_word(), 32'h500 + 32'(4 * i), 0, 0);
        total_cnt++; if (count_a !== 3'd3) $display("FAIL flush_pre got cnt=%0d want 3", count_a); else pass_cnt++;
        drive(1, 32'h00A00093, 32'h5F0, 0, 1);
        total_cnt++; if ({count_a, qa.out_valid, qa.out_id} !== {3'd0, 1'b0, 6'd45})
            $display("FAIL flush got cnt=%0d v=%0b id=%0d want 0 0 45", count_a, qa.out_valid, qa.out_id); else pass_cnt++;
        drive(0, 0, 0, 1, 0);
        total_cnt++; if ({count_a, qa.out_valid, qa.out_pc} !== {3'd0, 1'b0, 32'd0})
            $display("FAIL flush_after got cnt=%0d v=%0b pc=%h want 0 0 0", count_a, qa.out_valid, qa.out_pc); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        drive(1, 32'h00500093, 32'h600, 0, 0);
        drive(1, 32'h00000037, 32'h604, 0, 0);
        total_cnt++; if (count_a !== 3'd2) $display("FAIL areset_pre got cnt=%0d want 2", count_a); else pass_cnt++;
        qa.in_valid = 0;
        #2 rst = 1;
        #1;
        total_cnt++; if ({count_a, qa.out_valid, qa.in_ready, qa.out_instr, qa.out_pc, qa.out_id, qa.out_illegal}
                         !== {3'd0, 1'b0, 1'b1, 32'd0, 32'd0, 6'd45, 1'b0})
            $display("FAIL areset got cnt=%0d v=%0b r=%0b id=%0d want 0 0 1 45", count_a, qa.out_valid, qa.in_ready, qa.out_id);
        else pass_cnt++;
        #1 rst = 0;
        mq.delete();
        drive(1, 32'h00000017, 32'h700, 0, 0);
        total_cnt++; if ({count_a, qa.out_id, qa.out_pc} !== {3'd1, 6'd44, 32'h700})
            $display("FAIL areset_after got cnt=%0d id=%0d pc=%h want 1 44 700", count_a, qa.out_id, qa.out_pc); else pass_cnt++;
        drive(0, 0, 0, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, rand_word(), $urandom, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0);
            total_cnt++;
            if ({count_a, qa.in_ready, qa.out_valid, qa.out_instr, qa.out_pc, qa.out_id, qa.out_illegal} !==
                {3'(mq.size()), mq.size() != DEPTH, mq.size() != 0, exp_instr(), exp_pc(), exp_id(1),
                 mq.size() != 0 && exp_id(1) == 6'd45})
                $display("FAIL rand_m1[%0d] got cnt=%0d instr=%h pc=%h id=%0d ill=%0b want cnt=%0d instr=%h pc=%h id=%0d",
                         i, count_a, qa.out_instr, qa.out_pc, qa.out_id, qa.out_illegal,
                         mq.size(), exp_instr(), exp_pc(), exp_id(1));
            else pass_cnt++;
            total_cnt++;
            if ({count_b, qb.out_id, qb.out_illegal} !== {3'(mq.size()), exp_id(0), mq.size() != 0 && exp_id(0) == 6'd45})
                $display("FAIL rand_m0[%0d] got cnt=%0d id=%0d ill=%0b want cnt=%0d id=%0d",
                         i, count_b, qb.out_id, qb.out_illegal, mq.size(), exp_id(0));
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_order_and_m();
        test_full();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
